// File: rtl/count_pkg.sv
// Shared types and helpers for the photon-count reader and its FIFO bench.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package count_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    EMIT = 2'd2
  } state_t;

  // One lane carries {bright, count}, so it is one bit wider than a count.
  function automatic int lane_w(input int count_w);
    return count_w + 1;
  endfunction

  // Low bit of lane 'lane' inside a packed output word.
  function automatic int lane_lsb(input int lane, input int lw);
    return lane * lw;
  endfunction

endpackage

// File: rtl/count_lane_pack.sv
// Lane packer: classifies each popped count against THRESH and stores it in the next lane.
// Latency: lane and keep registers update on the clock after cap is asserted.
// Backpressure: none internally; the parent only asserts cap when a word is not being held.
module count_lane_pack
  import count_pkg::*;
#(
  parameter int COUNT_W = 7,
  parameter int LANES   = 4,
  localparam int LW     = lane_w(COUNT_W),
  localparam int IW     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap,
  input  logic                  clr,
  input  logic [COUNT_W-1:0]    fifo_data,
  input  logic [COUNT_W-1:0]    thresh,
  output logic [LANES*LW-1:0]   lane_dat,
  output logic [LANES-1:0]      keep,
  output logic                  idx_nz,
  output logic                  full
);

  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

  logic [LANES*LW-1:0] data_q;
  logic [LANES-1:0]    keep_q;
  logic [IW-1:0]       idx_q;
  logic                bright;

  // Unsigned compare; equal to the threshold counts as bright.
  assign bright = (fifo_data >= thresh);

  // Fill lanes from lane 0 upward; a handshake or reset empties the word.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data_q <= '0;
      keep_q <= '0;
      idx_q  <= '0;
    end else if (cap) begin
      data_q[lane_lsb(int'(idx_q), LW) +: LW] <= {bright, fifo_data};
      keep_q[idx_q] <= 1'b1;
      // The last lane leaves idx in place; the handshake that follows resets it.
      if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
    end
  end

  assign lane_dat = data_q;
  assign keep     = keep_q;
  assign idx_nz   = (idx_q != '0);
  assign full     = (idx_q == LAST_IDX);

endmodule

// File: rtl/count_reader.sv
// Photon-count FIFO consumer: pops counts, tags bright/dark, and packs LANES lanes per stream word.
// Latency: 2 cycles from the FIFO_RD of the last lane to OUT_VALID; one count per 2 cycles.
// Backpressure: OUT_READY low holds the word and stops all pops. Optional COUNT_READER_STATS_EN adds shot and bright counters.
module count_reader
  import count_pkg::*;
#(
  parameter int COUNT_W = 7,
  parameter int LANES   = 4,
  parameter int TIMEOUT = 1024,
  localparam int LW     = lane_w(COUNT_W)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [COUNT_W-1:0]    FIFO_DATA,
  input  logic [6:0]            FIFO_USAGE,
  input  logic                  FIFO_INT,
  output logic                  FIFO_RD,
  input  logic [COUNT_W-1:0]    THRESH,
  output logic [LANES*LW-1:0]   OUT_DATA,
  output logic [LANES-1:0]      OUT_KEEP,
  output logic                  OUT_LAST,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY
`ifdef COUNT_READER_STATS_EN
  ,
  output logic [31:0]           SHOT_CNT,
  output logic [31:0]           BRIGHT_CNT
`endif
);

  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic          pop;
  logic          set_last;
  logic          last_q;
  logic          int_q;
  logic          int_pend;
  logic [TW-1:0] tmo;
  logic          cap;
  logic          hs;
  logic          last_hs;
  logic          idx_nz;
  logic          full;
  logic          fifo_empty;

  assign fifo_empty = (FIFO_USAGE == 7'd0);
  assign cap        = (state == CAP);
  assign hs         = (state == EMIT) && OUT_READY;
  assign last_hs    = hs && last_q;

  count_lane_pack #(
    .COUNT_W (COUNT_W),
    .LANES   (LANES)
  ) u_pack (
    .clk       (CLK),
    .rst       (RST),
    .cap       (cap),
    .clr       (hs),
    .fifo_data (FIFO_DATA),
    .thresh    (THRESH),
    .lane_dat  (OUT_DATA),
    .keep      (OUT_KEEP),
    .idx_nz    (idx_nz),
    .full      (full)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: pops take priority; an empty FIFO then honours end-of-window, then timeout.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    set_last  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = CAP;
        end else if (int_pend) begin
          set_last  = 1'b1;
          state_nxt = EMIT;
        end else if (idx_nz && (tmo == TMO_MAX)) begin
          state_nxt = EMIT;
        end
      end
      CAP:     state_nxt = full ? EMIT : IDLE;
      EMIT:    if (OUT_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign FIFO_RD   = pop && !RST;
  assign OUT_VALID = (state == EMIT);
  assign OUT_LAST  = last_q;

  // LAST flag travels with the held word and drops once it is accepted.
  always_ff @(posedge CLK) begin
    if (RST || hs)     last_q <= 1'b0;
    else if (set_last) last_q <= 1'b1;
  end

  // Rising-edge detect on the interrupt level; a second edge before the LAST word is ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      int_q    <= 1'b0;
      int_pend <= 1'b0;
    end else begin
      int_q <= FIFO_INT;
      if (last_hs)                   int_pend <= 1'b0;
      else if (FIFO_INT && !int_q)   int_pend <= 1'b1;
    end
  end

  // Idle timer for a partial word sitting behind an empty FIFO; saturates at the flush point.
  always_ff @(posedge CLK) begin
    if (RST || pop || hs)
      tmo <= '0;
    else if ((state == IDLE) && fifo_empty && idx_nz && (tmo != TMO_MAX))
      tmo <= tmo + 1'b1;
  end

`ifdef COUNT_READER_STATS_EN
  logic cap_bright;
  assign cap_bright = (FIFO_DATA >= THRESH);

  // Per-window capture tallies, saturating, cleared when the LAST word is accepted.
  always_ff @(posedge CLK) begin
    if (RST || last_hs) begin
      SHOT_CNT   <= '0;
      BRIGHT_CNT <= '0;
    end else if (cap) begin
      if (SHOT_CNT != '1)                 SHOT_CNT   <= SHOT_CNT + 32'd1;
      if (cap_bright && BRIGHT_CNT != '1) BRIGHT_CNT <= BRIGHT_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_count_reader.sv
// Directed bench for count_reader with a small behavioural FIFO in front of it.
// Latency: checks the 2-cycle pop-to-valid path and the idle-timeout flush.
// Backpressure: holds OUT_READY low to confirm the FIFO is not drained.
module tb_count_reader;

  localparam int TIMEOUT = 1024;

  logic        CLK;
  logic        RST;
  logic [6:0]  FIFO_DATA;
  wire  [6:0]  FIFO_USAGE;
  logic        FIFO_INT;
  logic        FIFO_RD;
  logic [6:0]  THRESH;
  logic [31:0] OUT_DATA;
  logic [3:0]  OUT_KEEP;
  logic        OUT_LAST;
  logic        OUT_VALID;
  logic        OUT_READY;
`ifdef COUNT_READER_STATS_EN
  logic [31:0] shot_cnt;
  logic [31:0] bright_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Behavioural FIFO: tasks push, pops return data the cycle after FIFO_RD.
  logic [6:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign FIFO_USAGE = 7'(wr_ptr - rd_ptr);

  always @(posedge CLK) begin
    if (FIFO_RD) begin
      FIFO_DATA <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  count_reader #(
    .COUNT_W (7),
    .LANES   (4),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .FIFO_DATA  (FIFO_DATA),
    .FIFO_USAGE (FIFO_USAGE),
    .FIFO_INT   (FIFO_INT),
    .FIFO_RD    (FIFO_RD),
    .THRESH     (THRESH),
    .OUT_DATA   (OUT_DATA),
    .OUT_KEEP   (OUT_KEEP),
    .OUT_LAST   (OUT_LAST),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY)
`ifdef COUNT_READER_STATS_EN
    ,
    .SHOT_CNT   (shot_cnt),
    .BRIGHT_CNT (bright_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic push(input logic [6:0] v);
    mem[wr_ptr % 64] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  // Waits on falling edges until OUT_VALID or the limit; reports cycles spent.
  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    while (!OUT_VALID && cycles < limit) begin
      @(negedge CLK);
      cycles++;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    compared++; if (FIFO_RD !== 1'b0)   begin mismatched++; $display("FAIL reset_rd got %b want 0", FIFO_RD); end
    compared++; if (OUT_VALID !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", OUT_VALID); end
    compared++; if (OUT_LAST !== 1'b0)  begin mismatched++; $display("FAIL reset_last got %b want 0", OUT_LAST); end
    compared++; if (OUT_KEEP !== 4'h0)  begin mismatched++; $display("FAIL reset_keep got %h want 0", OUT_KEEP); end
    compared++; if (OUT_DATA !== 32'h0) begin mismatched++; $display("FAIL reset_data got %h want 0", OUT_DATA); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_full_word;
    int cyc;
    THRESH = 7'd3;
    push(7'd0); push(7'd3); push(7'd5); push(7'd2);
    wait_valid(40, cyc);
    compared++; if (cyc >= 40)            begin mismatched++; $display("FAIL full_timeout got %0d cycles want <40", cyc); end
    compared++; if (OUT_DATA !== 32'h02858300) begin mismatched++; $display("FAIL full_data got %h want 02858300", OUT_DATA); end
    compared++; if (OUT_KEEP !== 4'hF)    begin mismatched++; $display("FAIL full_keep got %h want f", OUT_KEEP); end
    compared++; if (OUT_LAST !== 1'b0)    begin mismatched++; $display("FAIL full_last got %b want 0", OUT_LAST); end
    @(posedge CLK); @(negedge CLK);
    compared++; if (OUT_VALID !== 1'b0)   begin mismatched++; $display("FAIL full_release got %b want 0", OUT_VALID); end
  endtask

  task automatic test_timeout;
    int cyc;
    THRESH = 7'd3;
    push(7'd9); push(7'd1);
    wait_valid(2000, cyc);
    compared++; if (cyc < TIMEOUT || cyc > TIMEOUT + 10) begin mismatched++; $display("FAIL tmo_cycles got %0d want %0d..%0d", cyc, TIMEOUT, TIMEOUT + 10); end
    compared++; if (OUT_DATA !== 32'h00000189) begin mismatched++; $display("FAIL tmo_data got %h want 00000189", OUT_DATA); end
    compared++; if (OUT_KEEP !== 4'h3)    begin mismatched++; $display("FAIL tmo_keep got %h want 3", OUT_KEEP); end
    compared++; if (OUT_LAST !== 1'b0)    begin mismatched++; $display("FAIL tmo_last got %b want 0", OUT_LAST); end
    @(posedge CLK); @(negedge CLK);
  endtask

  task automatic test_int_partial;
    int cyc;
    int seen;
    THRESH = 7'd3;
    push(7'd7); push(7'd2); push(7'd3);
    repeat (10) @(negedge CLK);
    FIFO_INT = 1'b1;
    wait_valid(20, cyc);
    compared++; if (cyc >= 20)            begin mismatched++; $display("FAIL int_wait got %0d cycles want <20", cyc); end
    compared++; if (OUT_DATA !== 32'h00830287) begin mismatched++; $display("FAIL int_data got %h want 00830287", OUT_DATA); end
    compared++; if (OUT_KEEP !== 4'h7)    begin mismatched++; $display("FAIL int_keep got %h want 7", OUT_KEEP); end
    compared++; if (OUT_LAST !== 1'b1)    begin mismatched++; $display("FAIL int_last got %b want 1", OUT_LAST); end
    @(posedge CLK); @(negedge CLK);
    // Interrupt still high but no new edge: a cleared int_pend must not emit again.
    seen = 0;
    repeat (20) begin
      if (OUT_VALID) seen++;
      @(negedge CLK);
    end
    compared++; if (seen != 0)            begin mismatched++; $display("FAIL int_pend_clear got %0d valid cycles want 0", seen); end
    FIFO_INT = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_backpressure;
    int cyc;
    int rd_seen;
    int chg_seen;
    int drop_seen;
    THRESH = 7'd3;
    OUT_READY = 1'b0;
    push(7'd10); push(7'd20); push(7'd30); push(7'd40);
    push(7'd1);  push(7'd2);  push(7'd3);  push(7'd4);
    wait_valid(40, cyc);
    compared++; if (OUT_DATA !== 32'hA89E948A) begin mismatched++; $display("FAIL bp_data got %h want a89e948a", OUT_DATA); end
    rd_seen = 0; chg_seen = 0; drop_seen = 0;
    repeat (50) begin
      @(negedge CLK);
      if (FIFO_RD)                    rd_seen++;
      if (OUT_DATA !== 32'hA89E948A)  chg_seen++;
      if (!OUT_VALID)                 drop_seen++;
    end
    compared++; if (rd_seen != 0)     begin mismatched++; $display("FAIL bp_no_pop got %0d pops want 0", rd_seen); end
    compared++; if (chg_seen != 0)    begin mismatched++; $display("FAIL bp_stable got %0d changes want 0", chg_seen); end
    compared++; if (drop_seen != 0)   begin mismatched++; $display("FAIL bp_valid_held got %0d drops want 0", drop_seen); end
    compared++; if (FIFO_USAGE !== 7'd4) begin mismatched++; $display("FAIL bp_usage got %0d want 4", FIFO_USAGE); end
    OUT_READY = 1'b1;
    @(posedge CLK); @(negedge CLK);
    wait_valid(40, cyc);
    compared++; if (OUT_DATA !== 32'h84830201) begin mismatched++; $display("FAIL bp_word2 got %h want 84830201", OUT_DATA); end
    compared++; if (OUT_KEEP !== 4'hF)  begin mismatched++; $display("FAIL bp_keep2 got %h want f", OUT_KEEP); end
    @(posedge CLK); @(negedge CLK);
  endtask

  task automatic test_end_marker;
    int cyc;
    FIFO_INT = 1'b1;
    wait_valid(20, cyc);
    compared++; if (cyc >= 20)          begin mismatched++; $display("FAIL mark_wait got %0d cycles want <20", cyc); end
    compared++; if (OUT_KEEP !== 4'h0)  begin mismatched++; $display("FAIL mark_keep got %h want 0", OUT_KEEP); end
    compared++; if (OUT_LAST !== 1'b1)  begin mismatched++; $display("FAIL mark_last got %b want 1", OUT_LAST); end
    compared++; if (OUT_DATA !== 32'h0) begin mismatched++; $display("FAIL mark_data got %h want 0", OUT_DATA); end
    @(posedge CLK); @(negedge CLK);
    FIFO_INT = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_midword;
    int cyc;
    int seen;
    THRESH = 7'd6;
    push(7'd100); push(7'd101);
    repeat (8) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge CLK);
      if (OUT_VALID) seen++;
    end
    compared++; if (seen != 0)          begin mismatched++; $display("FAIL rst_no_emit got %0d valid cycles want 0", seen); end
    push(7'd4); push(7'd5); push(7'd6); push(7'd7);
    wait_valid(40, cyc);
    compared++; if (OUT_DATA !== 32'h87860504) begin mismatched++; $display("FAIL rst_clean_data got %h want 87860504", OUT_DATA); end
    compared++; if (OUT_KEEP !== 4'hF)  begin mismatched++; $display("FAIL rst_clean_keep got %h want f", OUT_KEEP); end
    @(posedge CLK); @(negedge CLK);
  endtask

  initial begin
    RST       = 1'b1;
    FIFO_INT  = 1'b0;
    THRESH    = 7'd0;
    OUT_READY = 1'b1;
    test_reset();
    test_full_word();
    test_timeout();
    test_int_partial();
    test_backpressure();
    test_end_marker();
    test_reset_midword();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
